// File: rtl/misc_mem_pkg.sv
// Shared definitions for the fetch / load-store memory arbiter.
// Port ids double as bit positions in the two-bit request/grant vectors.
package misc_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_LS = 2'd2
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; holds the last-winner pointer.
// Grant is combinational from req and the registered pointer.
module rr_arb2
    import misc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;
    logic pick;

    always_comb begin
        pick = last;
        unique case (req)
            2'b01:   pick = PORT_IF;
            2'b10:   pick = PORT_LS;
            2'b11:   pick = ~last;
            default: pick = last;
        endcase
    end

    always_comb begin
        gnt = 2'b00;
        if (|req) begin
            gnt = (pick == PORT_LS) ? 2'b10 : 2'b01;
        end
    end

    // Reset value makes ls win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= PORT_IF;
        end else if (|req) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one synchronous memory.
// Read data is routed back one cycle after grant via the owner state.
module mem_arbiter
    import misc_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    logic [1:0] req;
    logic [1:0] gnt;
    owner_e     state;
    owner_e     state_nx;

    assign req[PORT_IF] = if_req;
    assign req[PORT_LS] = ls_req;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign if_gnt = gnt[PORT_IF];
    assign ls_gnt = gnt[PORT_LS];

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_we   = 1'b0;
        unique case (1'b1)
            gnt[PORT_LS]: begin
                mem_addr = ls_addr;
                mem_data = ls_wdata;
                mem_we   = ls_we;
            end
            gnt[PORT_IF]: begin
                mem_addr = if_addr;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Every cycle re-decides ownership, so a response never stalls a grant.
    always_comb begin
        state_nx = IDLE;
        unique case (1'b1)
            gnt[PORT_IF]:           state_nx = RESP_IF;
            gnt[PORT_LS] && !ls_we: state_nx = RESP_LS;
            default:                state_nx = IDLE;
        endcase
    end

    always_comb begin
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        unique case (state)
            RESP_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_q;
            end
            RESP_LS: begin
                ls_rvalid = 1'b1;
                ls_rdata  = mem_q;
            end
            default: begin
                if_rvalid = 1'b0;
            end
        endcase
    end

endmodule
